fetch_unit: RTL and testbench

- Instruction-fetch stage: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the stall/flush controls PCEn_i, IF_ID_En_i, IF_Flush_i and the redirect target, and obeys them over a multi-cycle memory interface.
- Sits between instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_unit and its IF/ID register.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, load beats hold.
// A bubble carries a NOP with a zero PC so decode sees a clean slot.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bubble,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] instr_d,
    input  logic [ADDR_WIDTH-1:0] pc_d,
    output logic                  valid_q,
    output logic [DATA_WIDTH-1:0] instr_q,
    output logic [ADDR_WIDTH-1:0] pc_q
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid_q <= 1'b0;
            instr_q <= DATA_WIDTH'(NOP_INSTR);
            pc_q    <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request FSM and IF/ID register.
// Handles multi-cycle memory with stall, flush and redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCEn_i,
    input  logic                  IF_ID_En_i,
    input  logic                  IF_Flush_i,
    input  logic [ADDR_WIDTH-1:0] redirect_target_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    fetch_state_t          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] buf_q;

    logic                  flush;
    logic                  adv;
    logic                  ack;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc_inc;

    logic                  ld;
    logic                  bub;
    logic [DATA_WIDTH-1:0] ld_instr;

    assign flush  = IF_Flush_i;
    assign adv    = PCEn_i & IF_ID_En_i & ~flush;
    assign target = redirect_target_i & ~ADDR_WIDTH'(3);
    assign pc_inc = pc_q + ADDR_WIDTH'(4);

    // An ack can only belong to a live request; anything else is ignored.
    assign imem_req_o  = ~rst & (state_q != HOLD);
    assign imem_addr_o = (state_q == DRAIN) ? addr_q : pc_q;
    assign ack         = imem_ack_i & imem_req_o;

    always_comb begin
        ld       = 1'b0;
        bub      = 1'b0;
        ld_instr = imem_rdata_i;
        unique case (state_q)
            FETCH: begin
                if (ack) begin
                    if (flush)    bub = 1'b1;
                    else if (adv) ld  = 1'b1;
                end else begin
                    if (flush)           bub = 1'b1;
                    else if (IF_ID_En_i) bub = 1'b1;
                end
            end
            HOLD: begin
                ld_instr = buf_q;
                if (flush)    bub = 1'b1;
                else if (adv) ld  = 1'b1;
            end
            DRAIN: begin
                if (flush)           bub = 1'b1;
                else if (IF_ID_En_i) bub = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack) begin
                        if (flush) begin
                            pc_q <= target;
                        end else if (adv) begin
                            pc_q <= pc_inc;
                        end else begin
                            buf_q   <= imem_rdata_i;
                            state_q <= HOLD;
                        end
                    end else if (flush) begin
                        addr_q  <= pc_q;
                        pc_q    <= target;
                        state_q <= DRAIN;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        pc_q    <= target;
                        state_q <= FETCH;
                    end else if (adv) begin
                        pc_q    <= pc_inc;
                        state_q <= FETCH;
                    end
                end
                DRAIN: begin
                    // Old request stays on the bus; late redirects just retarget.
                    if (flush) pc_q <= target;
                    if (ack)   state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    if_id_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .bubble (bub),
        .load   (ld),
        .instr_d(ld_instr),
        .pc_d   (pc_q),
        .valid_q(valid_o),
        .instr_q(instr_o),
        .pc_q   (pc_o)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Inputs change 1ns after the rising edge; outputs are sampled before the next.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCEn_i;
    logic        IF_ID_En_i;
    logic        IF_Flush_i;
    logic [31:0] redirect_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .PCEn_i           (PCEn_i),
        .IF_ID_En_i       (IF_ID_En_i),
        .IF_Flush_i       (IF_Flush_i),
        .redirect_target_i(redirect_target_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .valid_o          (valid_o),
        .instr_o          (instr_o),
        .pc_o             (pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic req,
                           input logic [31:0] addr);
        #1;
        check({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, req});
        if (req) check({tag, "_addr"}, imem_addr_o, addr);
    endtask

    task automatic chk_ifid(input string tag, input logic v,
                            input logic [31:0] ins, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
        check({tag, "_instr"}, instr_o, ins);
        if (v) check({tag, "_pc"}, pc_o, pc);
    endtask

    initial begin
        rst               = 1'b1;
        PCEn_i            = 1'b0;
        IF_ID_En_i        = 1'b0;
        IF_Flush_i        = 1'b0;
        redirect_target_i = '0;
        imem_ack_i        = 1'b0;
        imem_rdata_i      = '0;

        // reset state
        tick();
        tick();
        chk_req("rst", 1'b0, 32'h0);
        chk_ifid("rst", 1'b0, NOP, 32'h0);
        check("rst_pc", pc_o, 32'h0);

        // zero-wait memory, one instruction per cycle
        rst        = 1'b0;
        PCEn_i     = 1'b1;
        IF_ID_En_i = 1'b1;
        imem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata_i = 32'h1000_0000 + i;
            chk_req("zw", 1'b1, 32'(i * 4));
            tick();
            chk_ifid("zw", 1'b1, 32'h1000_0000 + i, 32'(i * 4));
        end

        // two-cycle memory: bubble before each instruction
        for (int i = 0; i < 2; i++) begin
            imem_ack_i = 1'b0;
            chk_req("lat_wait", 1'b1, 32'h10 + 32'(i * 4));
            tick();
            chk_ifid("lat_bub", 1'b0, NOP, 32'h0);
            imem_ack_i   = 1'b1;
            imem_rdata_i = 32'h2000_0010 + 32'(i * 4);
            chk_req("lat_ack", 1'b1, 32'h10 + 32'(i * 4));
            tick();
            chk_ifid("lat_ld", 1'b1, 32'h2000_0010 + 32'(i * 4),
                     32'h10 + 32'(i * 4));
        end

        // ack during stall is buffered, IF/ID frozen, req dropped
        PCEn_i       = 1'b0;
        IF_ID_En_i   = 1'b0;
        imem_rdata_i = 32'hDEAD_BEEF;
        chk_req("stall_ack", 1'b1, 32'h18);
        tick();
        chk_ifid("stall0", 1'b1, 32'h2000_0014, 32'h14);
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            chk_req("hold", 1'b0, 32'h0);
            tick();
            chk_ifid("stall", 1'b1, 32'h2000_0014, 32'h14);
        end
        PCEn_i     = 1'b1;
        IF_ID_En_i = 1'b1;
        chk_req("hold_rel", 1'b0, 32'h0);
        tick();
        chk_ifid("hold_rel", 1'b1, 32'hDEAD_BEEF, 32'h18);

        // flush to 0x100 while a request to 0x20 is pending
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h3000_001C;
        chk_req("pre_fl", 1'b1, 32'h1C);
        tick();
        chk_ifid("pre_fl", 1'b1, 32'h3000_001C, 32'h1C);
        imem_ack_i = 1'b0;
        chk_req("pend", 1'b1, 32'h20);
        tick();
        IF_Flush_i        = 1'b1;
        IF_ID_En_i        = 1'bx;
        redirect_target_i = 32'h100;
        chk_req("fl_pend", 1'b1, 32'h20);
        tick();
        chk_ifid("fl_pend", 1'b0, NOP, 32'h0);
        IF_Flush_i = 1'b0;
        IF_ID_En_i = 1'b1;
        chk_req("drain0", 1'b1, 32'h20);
        tick();
        chk_ifid("drain0", 1'b0, NOP, 32'h0);
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h0BAD_0BAD;
        chk_req("drain_ack", 1'b1, 32'h20);
        tick();
        chk_ifid("drain_ack", 1'b0, NOP, 32'h0);
        imem_rdata_i = 32'h1234_5678;
        chk_req("redir", 1'b1, 32'h100);
        tick();
        chk_ifid("redir", 1'b1, 32'h1234_5678, 32'h100);

        // flush with misaligned target while holding a buffered instr
        PCEn_i       = 1'b0;
        IF_ID_En_i   = 1'b0;
        imem_rdata_i = 32'hCAFE_F00D;
        tick();
        imem_ack_i        = 1'b0;
        IF_Flush_i        = 1'b1;
        redirect_target_i = 32'h203;
        chk_req("hold_fl", 1'b0, 32'h0);
        tick();
        chk_ifid("hold_fl", 1'b0, NOP, 32'h0);
        IF_Flush_i = 1'b0;
        PCEn_i     = 1'b1;
        IF_ID_En_i = 1'b1;
        chk_req("align", 1'b1, 32'h200);
        tick();

        // reset while a request is outstanding; stale ack is ignored
        rst        = 1'b1;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'h5555_AAAA;
        chk_req("rst_mid", 1'b0, 32'h0);
        tick();
        chk_req("rst_ack", 1'b0, 32'h0);
        tick();
        rst        = 1'b0;
        imem_ack_i = 1'b0;
        chk_req("post_rst", 1'b1, 32'h0);
        chk_ifid("post_rst", 1'b0, NOP, 32'h0);
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h0000_0077;
        tick();
        chk_ifid("post_rst_ld", 1'b1, 32'h77, 32'h0);

        // silent PC wrap at top of address space
        IF_Flush_i        = 1'b1;
        redirect_target_i = 32'hFFFF_FFFC;
        tick();
        IF_Flush_i   = 1'b0;
        imem_rdata_i = 32'h0000_0088;
        chk_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
        tick();
        chk_ifid("wrap_ld", 1'b1, 32'h88, 32'hFFFF_FFFC);
        chk_req("wrap_zero", 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
